fetch_exec_ctrl: RTL and testbench
==================================

Name: fetch_exec_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit baby-CR16 datapath; the successor to the fixed-sequence demo controller.
- Fetches instructions from memory over a req/ready handshake and decodes R-type, immediate, load/store, branch and halt classes.
- Drives the existing regfile/ALU control bus: wEnable, Rdest_sel, Rsrc_sel, opcode, Imm_in, Imm_sel.
- Parametrised in data width, address width, register count and reset PC.

Parameters:
- DATA_W, 16, datapath width; must be >= 16.
- ADDR_W, 16, PC and memory address width.
- NUM_REGS, 16, number of registers (2..16); sets the wEnable width.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current request this cycle.
- Flags_in  in  5  ALU flags {C,L,F,Z,N}; bit4=C, bit1=Z.
- rdest_data  in  DATA_W  regfile read port A (addressed by Rdest_sel).
- rsrc_data  in  DATA_W  regfile read port B (addressed by Rsrc_sel).
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe; valid with mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  store data.
- pc  out  ADDR_W  program counter.
- wEnable  out  NUM_REGS  one-hot register write enable.
- Rdest_sel  out  4  destination / read port A select.
- Rsrc_sel  out  4  source / read port B select.
- opcode  out  8  ALU operation code.
- Imm_in  out  DATA_W  extended immediate.
- Imm_sel  out  1  ALU B operand = Imm_in.
- flag_we  out  1  flag register update enable.
- wb_mem_sel  out  1  regfile write data = ld_data.
- ld_data  out  DATA_W  latched load data.
- halted  out  1  core stopped.
- err_illegal  out  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- Instruction fields: IR[15:12]=op, IR[11:8]=Rdest/cond, IR[7:4]=opext, IR[3:0]=Rsrc/Raddr, IR[7:0]=imm8/disp8.
- States: RESET, FETCH, DECODE, EXEC, MEM_RD, LD_WB, MEM_WR, BRANCH, HALT.
- Outputs are Moore, decoded from state + IR. Default for every output is 0; Rdest_sel=IR[11:8] and Rsrc_sel=IR[3:0] in all non-RESET states.
- Reset (async): state=RESET, pc=PC_RESET, IR=0, ld_data=0, all outputs 0. First clock after deassert: RESET->FETCH. Reset mid-transaction aborts immediately, with mem_req dropping asynchronously.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ready. On the ready edge: IR<=mem_rdata, pc<=pc+1 (wraps mod 2^ADDR_W), go to DECODE.
- DECODE: one cycle with no side effects. Branch on op:
  - op=0000 -> EXEC (R-type).
  - op in {0001,0010,0011,0101,0110,1001,1011,1101} -> EXEC (immediate).
  - op=0100, opext=0000 -> MEM_RD (LOAD).
  - op=0100, opext=0100 -> MEM_WR (STOR).
  - op=1100 -> BRANCH.
  - op=1111 -> HALT.
  - Anything else -> EXEC as illegal.
- EXEC, R-type:
  - opcode={op,opext}, Imm_sel=0.
  - wEnable[Rdest]=1 and flag_we=1.
  - CMP (opext=1011): flag_we=1 only, no register write.
  - NOP (opcode 00000000): no write, no flag update.
- EXEC, immediate:
  - opcode={op,4'b0000}, Imm_sel=1.
  - Imm_in = sign-extend(imm8) for ADDI(0101), SUBI(1001), CMPI(1011); zero-extend for ANDI/ORI/XORI/ADDUI/MOVI.
  - Writes as R-type; CMPI does not write a register.
- EXEC always returns to FETCH.
- Illegal instruction: in EXEC all enables are 0 and err_illegal=1 for that cycle. A Rdest >= NUM_REGS on a register write is also illegal, with no write performed.
- MEM_RD (LOAD Rdest,Raddr): mem_req=1, mem_addr=rsrc_data[ADDR_W-1:0]. Hold until mem_ready, then ld_data<=mem_rdata and go to LD_WB.
- LD_WB: wEnable[Rdest]=1, wb_mem_sel=1, then go to FETCH.
- MEM_WR (STOR Rsrc=IR[11:8], Raddr=IR[3:0]): mem_req=1, mem_we=1, mem_addr=rsrc_data, mem_wdata=rdest_data. Hold until mem_ready, then go to FETCH.
- BRANCH: cond=IR[11:8].
  - Conditions: 0000 EQ (Z=1), 0001 NE (Z=0), 0010 CS (C=1), 0011 CC (C=0), 1110 UC (always). Any other cond is not taken.
  - Taken: pc <= pc + sext(disp8). pc has already been incremented, so the target is relative to the next instruction; wraps mod 2^ADDR_W.
  - One cycle, then FETCH.
- HALT: halted=1, all other outputs 0. Absorbing until reset.
- Request rule: mem_req never deasserts before mem_ready, and mem_addr/mem_we/mem_wdata stay stable while mem_req=1 and mem_ready=0.
- Latency with zero-wait memory:
  - ALU op: 3 cycles (FETCH, DECODE, EXEC).
  - Load: 4 cycles.
  - Store: 3 cycles.
  - Branch: 3 cycles.

Test Plan:
- Reset with PC_RESET=0, then mem returns 0x5103 (ADDI r1,#3) with no wait: FETCH addr 0, DECODE, EXEC with wEnable=0x0002, Imm_in=0x0003, Imm_sel=1, opcode=0x50, flag_we=1; pc=1.
- ADDI r2,#0xFF: Imm_in=0xFFFF. ORI r2,#0xFF: Imm_in=0x00FF. CMPI: flag_we=1, wEnable=0.
- LOAD r3,[r4] with rsrc_data=0x0040 and mem_ready delayed 3 cycles: mem_addr=0x0040 held stable, LD_WB wEnable=0x0008, wb_mem_sel=1, ld_data=mem_rdata.
- BNE disp=0xFE at pc=5 with Z=0: pc 6 -> 4. Same instruction with Z=1: pc stays 6. UC at pc=0xFFFF with disp=+1: pc wraps to 0x0001.
- Opcode 0111: err_illegal pulses for 1 cycle, no enables, returns to FETCH. 0xF000: halted=1 forever, mem_req=0.
- Assert reset during MEM_WR wait: mem_req drops without a clock edge, pc=PC_RESET. Repeat with NUM_REGS=8, DATA_W=32 and Rdest=9: no write, err_illegal=1.

Source files
------------

// File: rtl/fetch_exec_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the baby-CR16 datapath.
// Every control output is registered from the next state and next instruction word.
module fetch_exec_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                NUM_REGS = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  input  logic [4:0]          Flags_in,
  input  logic [DATA_W-1:0]   rdest_data,
  input  logic [DATA_W-1:0]   rsrc_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]   pc,
  output logic [NUM_REGS-1:0] wEnable,
  output logic [3:0]          Rdest_sel,
  output logic [3:0]          Rsrc_sel,
  output logic [7:0]          opcode,
  output logic [DATA_W-1:0]   Imm_in,
  output logic                Imm_sel,
  output logic                flag_we,
  output logic                wb_mem_sel,
  output logic [DATA_W-1:0]   ld_data,
  output logic                halted,
  output logic                err_illegal
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM_RD = 4'd4,
    ST_LD_WB  = 4'd5,
    ST_MEM_WR = 4'd6,
    ST_BRANCH = 4'd7,
    ST_HALT   = 4'd8
  } state_t;

  localparam logic [4:0] NUM_REGS_L = 5'(NUM_REGS);

  state_t              state_r, state_nx_s;
  logic [15:0]         ir_r, ir_nx_s;
  logic [ADDR_W-1:0]   pc_r, pc_nx_s;
  logic                br_taken_s;
  logic [3:0]          op_s, rd_s, ext_s, rs_s;
  logic [7:0]          imm_s;
  logic                rd_ok_s;
  logic                flags_unused_s;

  logic                mem_req_nx_s, mem_we_nx_s, imm_sel_nx_s, flag_we_nx_s;
  logic                wb_mem_sel_nx_s, halted_nx_s, err_illegal_nx_s;
  logic [ADDR_W-1:0]   mem_addr_nx_s;
  logic [DATA_W-1:0]   mem_wdata_nx_s, imm_in_nx_s;
  logic [NUM_REGS-1:0] wen_nx_s;
  logic [3:0]          rdest_sel_nx_s, rsrc_sel_nx_s;
  logic [7:0]          opcode_nx_s;

  function automatic logic is_imm_op(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b0011, 4'b0101,
      4'b0110, 4'b1001, 4'b1011, 4'b1101: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_imm(input logic [3:0] op);
    case (op)
      4'b0101, 4'b1001, 4'b1011: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [3:0] r);
    logic [NUM_REGS-1:0] oh;
    for (int i = 0; i < NUM_REGS; i++) oh[i] = (4'(i) == r);
    return oh;
  endfunction

  assign op_s    = ir_nx_s[15:12];
  assign rd_s    = ir_nx_s[11:8];
  assign ext_s   = ir_nx_s[7:4];
  assign rs_s    = ir_nx_s[3:0];
  assign imm_s   = ir_nx_s[7:0];
  assign rd_ok_s = ({1'b0, rd_s} < NUM_REGS_L);
  assign pc      = pc_r;
  assign flags_unused_s = ^{Flags_in[3:2], Flags_in[0]};

  // Branch condition from the live flags: bit1 = Z, bit4 = C.
  always_comb begin
    case (ir_r[11:8])
      4'b0000: br_taken_s = Flags_in[1];
      4'b0001: br_taken_s = ~Flags_in[1];
      4'b0010: br_taken_s = Flags_in[4];
      4'b0011: br_taken_s = ~Flags_in[4];
      4'b1110: br_taken_s = 1'b1;
      default: br_taken_s = 1'b0;
    endcase
  end

  // Next state, next instruction register and next program counter.
  always_comb begin
    state_nx_s = state_r;
    ir_nx_s    = ir_r;
    pc_nx_s    = pc_r;
    case (state_r)
      ST_RESET: state_nx_s = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          ir_nx_s    = mem_rdata[15:0];
          pc_nx_s    = pc_r + ADDR_W'(1'b1);
          state_nx_s = ST_DECODE;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (ir_r[15:12] == 4'b0100 && ir_r[7:4] == 4'b0000) begin
          state_nx_s = ST_MEM_RD;
        end else if (ir_r[15:12] == 4'b0100 && ir_r[7:4] == 4'b0100) begin
          state_nx_s = ST_MEM_WR;
        end else if (ir_r[15:12] == 4'b1100) begin
          state_nx_s = ST_BRANCH;
        end else if (ir_r[15:12] == 4'b1111) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_EXEC;
        end
      end
      ST_EXEC:   state_nx_s = ST_FETCH;
      ST_MEM_RD: state_nx_s = mem_ready ? ST_LD_WB : ST_MEM_RD;
      ST_LD_WB:  state_nx_s = ST_FETCH;
      ST_MEM_WR: state_nx_s = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_BRANCH: begin
        state_nx_s = ST_FETCH;
        if (br_taken_s) begin
          pc_nx_s = pc_r + {{(ADDR_W-8){ir_r[7]}}, ir_r[7:0]};
        end else begin
          pc_nx_s = pc_r;
        end
      end
      ST_HALT:   state_nx_s = ST_HALT;
      default:   state_nx_s = ST_RESET;
    endcase
  end

  // Control outputs for the state about to be entered.
  always_comb begin
    mem_req_nx_s     = 1'b0;
    mem_we_nx_s      = 1'b0;
    mem_addr_nx_s    = {ADDR_W{1'b0}};
    mem_wdata_nx_s   = {DATA_W{1'b0}};
    wen_nx_s         = {NUM_REGS{1'b0}};
    opcode_nx_s      = 8'h00;
    imm_in_nx_s      = {DATA_W{1'b0}};
    imm_sel_nx_s     = 1'b0;
    flag_we_nx_s     = 1'b0;
    wb_mem_sel_nx_s  = 1'b0;
    halted_nx_s      = 1'b0;
    err_illegal_nx_s = 1'b0;
    if (state_nx_s != ST_RESET && state_nx_s != ST_HALT) begin
      rdest_sel_nx_s = rd_s;
      rsrc_sel_nx_s  = rs_s;
    end else begin
      rdest_sel_nx_s = 4'h0;
      rsrc_sel_nx_s  = 4'h0;
    end
    case (state_nx_s)
      ST_FETCH: begin
        mem_req_nx_s  = 1'b1;
        mem_addr_nx_s = pc_nx_s;
      end
      ST_EXEC: begin
        if (op_s == 4'b0000) begin
          opcode_nx_s = {op_s, ext_s};
          if (ext_s == 4'b0000) begin
            flag_we_nx_s = 1'b0;
          end else if (ext_s == 4'b1011) begin
            flag_we_nx_s = 1'b1;
          end else if (rd_ok_s) begin
            wen_nx_s     = reg_onehot(rd_s);
            flag_we_nx_s = 1'b1;
          end else begin
            err_illegal_nx_s = 1'b1;
          end
        end else if (is_imm_op(op_s)) begin
          opcode_nx_s  = {op_s, 4'b0000};
          imm_sel_nx_s = 1'b1;
          imm_in_nx_s  = is_signed_imm(op_s) ? {{(DATA_W-8){imm_s[7]}}, imm_s}
                                             : {{(DATA_W-8){1'b0}}, imm_s};
          if (op_s == 4'b1011) begin
            flag_we_nx_s = 1'b1;
          end else if (rd_ok_s) begin
            wen_nx_s     = reg_onehot(rd_s);
            flag_we_nx_s = 1'b1;
          end else begin
            err_illegal_nx_s = 1'b1;
          end
        end else begin
          err_illegal_nx_s = 1'b1;
        end
      end
      ST_MEM_RD: begin
        mem_req_nx_s  = 1'b1;
        mem_addr_nx_s = rsrc_data[ADDR_W-1:0];
      end
      ST_LD_WB: begin
        if (rd_ok_s) begin
          wen_nx_s        = reg_onehot(rd_s);
          wb_mem_sel_nx_s = 1'b1;
        end else begin
          err_illegal_nx_s = 1'b1;
        end
      end
      ST_MEM_WR: begin
        mem_req_nx_s   = 1'b1;
        mem_we_nx_s    = 1'b1;
        mem_addr_nx_s  = rsrc_data[ADDR_W-1:0];
        mem_wdata_nx_s = rdest_data;
      end
      ST_HALT: halted_nx_s = 1'b1;
      default: halted_nx_s = 1'b0;
    endcase
  end

  // State, instruction, pc, load data and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_RESET;
      ir_r        <= 16'h0000;
      pc_r        <= PC_RESET;
      ld_data     <= {DATA_W{1'b0}};
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_wdata   <= {DATA_W{1'b0}};
      wEnable     <= {NUM_REGS{1'b0}};
      Rdest_sel   <= 4'h0;
      Rsrc_sel    <= 4'h0;
      opcode      <= 8'h00;
      Imm_in      <= {DATA_W{1'b0}};
      Imm_sel     <= 1'b0;
      flag_we     <= 1'b0;
      wb_mem_sel  <= 1'b0;
      halted      <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      ir_r        <= ir_nx_s;
      pc_r        <= pc_nx_s;
      if (state_r == ST_MEM_RD && mem_ready) begin
        ld_data <= mem_rdata;
      end else begin
        ld_data <= ld_data;
      end
      mem_req     <= mem_req_nx_s;
      mem_we      <= mem_we_nx_s;
      mem_addr    <= mem_addr_nx_s;
      mem_wdata   <= mem_wdata_nx_s;
      wEnable     <= wen_nx_s;
      Rdest_sel   <= rdest_sel_nx_s;
      Rsrc_sel    <= rsrc_sel_nx_s;
      opcode      <= opcode_nx_s;
      Imm_in      <= imm_in_nx_s;
      Imm_sel     <= imm_sel_nx_s;
      flag_we     <= flag_we_nx_s;
      wb_mem_sel  <= wb_mem_sel_nx_s;
      halted      <= halted_nx_s;
      err_illegal <= err_illegal_nx_s;
    end
  end

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Directed bench for fetch_exec_ctrl: default instance plus an 8-register, 32-bit instance
// whose reset PC sits at the top of the address space.
module tb_fetch_exec_ctrl;

  logic        clk, reset, reset8;
  logic [15:0] mem_rdata, rdest_data, rsrc_data;
  logic        mem_ready;
  logic [4:0]  Flags_in;
  logic        mem_req, mem_we, Imm_sel, flag_we, wb_mem_sel, halted, err_illegal;
  logic [15:0] mem_addr, mem_wdata, pc, wEnable, Imm_in, ld_data;
  logic [3:0]  Rdest_sel, Rsrc_sel;
  logic [7:0]  opcode;

  logic [31:0] mem_rdata8, rdest_data8, rsrc_data8, mem_wdata8, Imm_in8, ld_data8;
  logic        mem_ready8, mem_req8, mem_we8, Imm_sel8, flag_we8, wb_mem_sel8, halted8, err_illegal8;
  logic [15:0] mem_addr8, pc8;
  logic [7:0]  wEnable8, opcode8;
  logic [3:0]  Rdest_sel8, Rsrc_sel8;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] got, exp;

  fetch_exec_ctrl dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .Flags_in(Flags_in), .rdest_data(rdest_data), .rsrc_data(rsrc_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc(pc), .wEnable(wEnable), .Rdest_sel(Rdest_sel), .Rsrc_sel(Rsrc_sel),
    .opcode(opcode), .Imm_in(Imm_in), .Imm_sel(Imm_sel), .flag_we(flag_we),
    .wb_mem_sel(wb_mem_sel), .ld_data(ld_data), .halted(halted), .err_illegal(err_illegal)
  );

  fetch_exec_ctrl #(.DATA_W(32), .ADDR_W(16), .NUM_REGS(8), .PC_RESET(16'hFFFF)) dut8 (
    .clk(clk), .reset(reset8), .mem_rdata(mem_rdata8), .mem_ready(mem_ready8),
    .Flags_in(5'b00000), .rdest_data(rdest_data8), .rsrc_data(rsrc_data8),
    .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .pc(pc8), .wEnable(wEnable8), .Rdest_sel(Rdest_sel8), .Rsrc_sel(Rsrc_sel8),
    .opcode(opcode8), .Imm_in(Imm_in8), .Imm_sel(Imm_sel8), .flag_we(flag_we8),
    .wb_mem_sel(wb_mem_sel8), .ld_data(ld_data8), .halted(halted8), .err_illegal(err_illegal8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction word with a zero-wait ready; returns in DECODE.
  task automatic do_fetch(input logic [15:0] insn);
    mem_rdata = insn;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    got = 128'({mem_req, mem_we, mem_addr, pc, wEnable, halted, err_illegal, Rdest_sel,
                Rsrc_sel, opcode, Imm_in, Imm_sel, flag_we, wb_mem_sel, ld_data});
    exp = 128'd0;
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL reset_outputs: got %h want %h", got, exp); end
    vectors++; if (pc8 !== 16'hFFFF) begin miscompares++; $display("FAIL reset_pc8: got %h want ffff", pc8); end
    reset = 1'b0;
    tick();
    got = 128'({mem_req, mem_we, mem_addr}); exp = 128'({1'b1, 1'b0, 16'h0000});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL reset_first_fetch: got %h want %h", got, exp); end
  endtask

  task automatic test_addi();
    do_fetch(16'h5103);
    got = 128'({pc, mem_req, wEnable, Rdest_sel, Rsrc_sel});
    exp = 128'({16'h0001, 1'b0, 16'h0000, 4'h1, 4'h3});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL addi_decode: got %h want %h", got, exp); end
    tick();
    got = 128'({wEnable, Imm_in, Imm_sel, opcode, flag_we, err_illegal});
    exp = 128'({16'h0002, 16'h0003, 1'b1, 8'h50, 1'b1, 1'b0});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL addi_exec: got %h want %h", got, exp); end
    tick();
    got = 128'({mem_req, mem_addr, wEnable, flag_we}); exp = 128'({1'b1, 16'h0001, 16'h0000, 1'b0});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL addi_refetch: got %h want %h", got, exp); end
  endtask

  task automatic test_imm_ext();
    logic [15:0] t_insn [6] = '{16'h52FF, 16'h22FF, 16'hB280, 16'h1381, 16'h9A80, 16'hD7F0};
    logic [15:0] t_wen  [6] = '{16'h0004, 16'h0004, 16'h0000, 16'h0008, 16'h0400, 16'h0080};
    logic [15:0] t_imm  [6] = '{16'hFFFF, 16'h00FF, 16'hFF80, 16'h0081, 16'hFF80, 16'h00F0};
    logic [7:0]  t_op   [6] = '{8'h50, 8'h20, 8'hB0, 8'h10, 8'h90, 8'hD0};
    for (int i = 0; i < 6; i++) begin
      do_fetch(t_insn[i]);
      tick();
      got = 128'({wEnable, Imm_in, Imm_sel, opcode, flag_we, err_illegal});
      exp = 128'({t_wen[i], t_imm[i], 1'b1, t_op[i], 1'b1, 1'b0});
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL imm_exec[%0d]: got %h want %h", i, got, exp); end
      tick();
    end
  endtask

  task automatic test_rtype();
    logic [15:0] t_insn [4] = '{16'h0556, 16'h05B6, 16'h0000, 16'h0F3D};
    logic [15:0] t_wen  [4] = '{16'h0020, 16'h0000, 16'h0000, 16'h8000};
    logic [7:0]  t_op   [4] = '{8'h05, 8'h0B, 8'h00, 8'h03};
    logic        t_flag [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_fetch(t_insn[i]);
      tick();
      got = 128'({wEnable, Imm_in, Imm_sel, opcode, flag_we, err_illegal});
      exp = 128'({t_wen[i], 16'h0000, 1'b0, t_op[i], t_flag[i], 1'b0});
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL rtype_exec[%0d]: got %h want %h", i, got, exp); end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [15:0] t_insn [3] = '{16'h7000, 16'h4310, 16'hE123};
    for (int i = 0; i < 3; i++) begin
      do_fetch(t_insn[i]);
      tick();
      got = 128'({wEnable, flag_we, wb_mem_sel, mem_req, err_illegal});
      exp = 128'({16'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL illegal_exec[%0d]: got %h want %h", i, got, exp); end
      tick();
      got = 128'({err_illegal, mem_req}); exp = 128'({1'b0, 1'b1});
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL illegal_pulse[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_load();
    rsrc_data = 16'h0040;
    do_fetch(16'h4304);
    tick();
    for (int k = 0; k < 3; k++) begin
      got = 128'({mem_req, mem_we, mem_addr, wEnable}); exp = 128'({1'b1, 1'b0, 16'h0040, 16'h0000});
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL load_hold[%0d]: got %h want %h", k, got, exp); end
      tick();
    end
    mem_rdata = 16'hBEEF;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    got = 128'({wEnable, wb_mem_sel, ld_data, mem_req, flag_we});
    exp = 128'({16'h0008, 1'b1, 16'hBEEF, 1'b0, 1'b0});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL load_wb: got %h want %h", got, exp); end
    tick();
    got = 128'({mem_req, wb_mem_sel, ld_data, wEnable}); exp = 128'({1'b1, 1'b0, 16'hBEEF, 16'h0000});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL load_done: got %h want %h", got, exp); end
  endtask

  task automatic test_store();
    rdest_data = 16'h1234;
    rsrc_data  = 16'h0077;
    do_fetch(16'h4748);
    tick();
    for (int k = 0; k < 2; k++) begin
      got = 128'({mem_req, mem_we, mem_addr, mem_wdata, wEnable});
      exp = 128'({1'b1, 1'b1, 16'h0077, 16'h1234, 16'h0000});
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL store_req[%0d]: got %h want %h", k, got, exp); end
      if (k == 0) tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    got = 128'({mem_req, mem_we}); exp = 128'({1'b1, 1'b0});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL store_done: got %h want %h", got, exp); end
  endtask

  task automatic test_branch();
    logic [15:0] t_insn [4] = '{16'hC1FE, 16'hC1FE, 16'hC203, 16'hC303};
    logic [4:0]  t_flg  [4] = '{5'b00000, 5'b00010, 5'b10000, 5'b10000};
    logic [15:0] t_pc   [4] = '{16'h0004, 16'h0006, 16'h000A, 16'h000B};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      do_fetch(16'h0000);
      tick();
      tick();
    end
    vectors++; if (mem_addr !== 16'h0005) begin miscompares++; $display("FAIL branch_setup: got %h want 0005", mem_addr); end
    for (int i = 0; i < 4; i++) begin
      Flags_in = t_flg[i];
      do_fetch(t_insn[i]);
      tick();
      got = 128'({mem_req, wEnable, flag_we, err_illegal}); exp = 128'd0;
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL branch_quiet[%0d]: got %h want %h", i, got, exp); end
      tick();
      got = 128'({pc, mem_addr, mem_req}); exp = 128'({t_pc[i], t_pc[i], 1'b1});
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL branch_pc[%0d]: got %h want %h", i, got, exp); end
      if (i == 0) begin
        do_fetch(16'h0000);
        tick();
        tick();
      end
    end
    Flags_in = 5'b00000;
  endtask

  task automatic test_halt();
    reset_dut();
    do_fetch(16'hF000);
    tick();
    for (int i = 0; i < 5; i++) begin
      got = 128'({halted, mem_req, wEnable, err_illegal, Rdest_sel});
      exp = 128'({1'b1, 1'b0, 16'h0000, 1'b0, 4'h0});
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL halt_hold[%0d]: got %h want %h", i, got, exp); end
      mem_ready = (i % 2 == 0);
      tick();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    reset_dut();
    rdest_data = 16'h5A5A;
    rsrc_data  = 16'h0100;
    do_fetch(16'h4748);
    tick();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL midwr_req: got %b want 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    got = 128'({mem_req, mem_we, pc}); exp = 128'({1'b0, 1'b0, 16'h0000});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL midwr_async: got %h want %h", got, exp); end
    tick();
    reset = 1'b0;
    tick();
    got = 128'({mem_req, mem_we, mem_addr}); exp = 128'({1'b1, 1'b0, 16'h0000});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL midwr_restart: got %h want %h", got, exp); end
  endtask

  task automatic test_dut8();
    reset8 = 1'b0;
    tick();
    got = 128'({mem_req8, mem_addr8}); exp = 128'({1'b1, 16'hFFFF});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL n8_fetch: got %h want %h", got, exp); end
    mem_rdata8 = 32'h0000CE01; mem_ready8 = 1'b1;
    tick();
    mem_ready8 = 1'b0;
    vectors++; if (pc8 !== 16'h0000) begin miscompares++; $display("FAIL n8_pc_wrap: got %h want 0000", pc8); end
    tick();
    tick();
    got = 128'({pc8, mem_addr8}); exp = 128'({16'h0001, 16'h0001});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL n8_uc_target: got %h want %h", got, exp); end
    mem_rdata8 = 32'h00005903; mem_ready8 = 1'b1;
    tick();
    mem_ready8 = 1'b0;
    tick();
    got = 128'({wEnable8, flag_we8, err_illegal8}); exp = 128'({8'h00, 1'b0, 1'b1});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL n8_bad_rdest: got %h want %h", got, exp); end
    tick();
    mem_rdata8 = 32'h00005780; mem_ready8 = 1'b1;
    tick();
    mem_ready8 = 1'b0;
    tick();
    got = 128'({wEnable8, Imm_in8, err_illegal8, flag_we8}); exp = 128'({8'h80, 32'hFFFFFF80, 1'b0, 1'b1});
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL n8_addi_r7: got %h want %h", got, exp); end
  endtask

  initial begin
    reset = 1'b1; reset8 = 1'b1;
    mem_rdata = 16'h0000; mem_ready = 1'b0; Flags_in = 5'b00000;
    rdest_data = 16'h0000; rsrc_data = 16'h0000;
    mem_rdata8 = 32'h0; mem_ready8 = 1'b0; rdest_data8 = 32'h0; rsrc_data8 = 32'h0;
    test_reset();
    test_addi();
    test_imm_ext();
    test_rtype();
    test_illegal();
    test_load();
    test_store();
    test_branch();
    test_halt();
    test_reset_mid_write();
    test_dut8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
